// File: rtl/small_calculator_cu.sv
// Moore control unit for the small calculator datapath: load R1, load R2,
// compute R3 = R1 op R2, then gate the ALU result onto the output.
// Ports: clk, rst (sync, active-high), go/op request in;
//   s1, wa, we, raa, rea, rab, reb, c, s2 datapath controls out;
//   done, busy status out; cs current-state debug out.
// Optional: `define CALC_CLEAR_EN adds CLR1..CLR3, which zero R1..R3 after
//   each operation.
module small_calculator_cu (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] op,
  output logic [1:0] s1,
  output logic [1:0] wa,
  output logic       we,
  output logic [1:0] raa,
  output logic       rea,
  output logic [1:0] rab,
  output logic       reb,
  output logic [1:0] c,
  output logic       s2,
  output logic       done,
  output logic       busy,
  output logic [2:0] cs
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4,
    CLR1   = 3'd5,
    CLR2   = 3'd6,
    CLR3   = 3'd7
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [1:0] op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= 2'b00;
    end else begin
      state <= nxt;
      if (state == IDLE && go)
        op_q <= op;
    end
  end

  always_comb begin
    nxt  = IDLE;
    s1   = 2'b00;
    wa   = 2'b00;
    we   = 1'b0;
    raa  = 2'b00;
    rea  = 1'b0;
    rab  = 2'b00;
    reb  = 1'b0;
    c    = 2'b00;
    s2   = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        nxt = go ? LOAD_A : IDLE;
      end
      LOAD_A: begin
        s1  = 2'b01;
        wa  = 2'b01;
        we  = 1'b1;
        nxt = LOAD_B;
      end
      LOAD_B: begin
        s1  = 2'b10;
        wa  = 2'b10;
        we  = 1'b1;
        nxt = EXEC;
      end
      EXEC: begin
        rea = 1'b1;
        raa = 2'b01;
        reb = 1'b1;
        rab = 2'b10;
        c   = op_q;
        s1  = 2'b11;
        wa  = 2'b11;
        we  = 1'b1;
        nxt = DONE;
      end
      DONE: begin
        rea  = 1'b1;
        raa  = 2'b01;
        reb  = 1'b1;
        rab  = 2'b10;
        c    = op_q;
        s2   = 1'b1;
        done = 1'b1;
`ifdef CALC_CLEAR_EN
        nxt  = go ? DONE : CLR1;
`else
        nxt  = go ? DONE : IDLE;
`endif
      end
`ifdef CALC_CLEAR_EN
      CLR1: begin
        wa  = 2'b01;
        we  = 1'b1;
        nxt = CLR2;
      end
      CLR2: begin
        wa  = 2'b10;
        we  = 1'b1;
        nxt = CLR3;
      end
      CLR3: begin
        wa  = 2'b11;
        we  = 1'b1;
        nxt = IDLE;
      end
`endif
      // Unused encodings fall back to IDLE with all outputs low.
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign cs   = state;

endmodule
